// File: rtl/uart_baud_gen_frac_if.sv
// rtl/uart_baud_gen_frac_if.sv - divisor/control inputs and tick outputs of the fractional baud generator
interface uart_baud_gen_frac_if #(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 4,
  parameter int OVERSAMPLE = 16
);
  localparam int IDX_W = $clog2(OVERSAMPLE);

  logic                 enable;
  logic                 restart;
  logic [WIDTH-1:0]     baud_division;
  logic [FRAC_BITS-1:0] baud_frac;
  logic                 os_tick;
  logic                 mid_tick;
  logic                 baud_tick;
  logic [IDX_W-1:0]     os_index;

  modport master (
    output enable, restart, baud_division, baud_frac,
    input  os_tick, mid_tick, baud_tick, os_index
  );

  modport slave (
    input  enable, restart, baud_division, baud_frac,
    output os_tick, mid_tick, baud_tick, os_index
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional-divisor oversample tick generator with per-bit mid/baud ticks
module uart_baud_gen_frac #(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_baud_gen_frac_if.slave  bus
);
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] SUB_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] SUB_LAST = IDX_W'(OVERSAMPLE - 1);

  // One extra bit so the terminal value act_div + ext can reach 2^WIDTH without wrapping.
  logic [WIDTH:0]       cnt;
  logic [IDX_W-1:0]     sub;
  logic [FRAC_BITS-1:0] acc;
  logic                 ext;
  logic [WIDTH-1:0]     act_div;
  logic [FRAC_BITS-1:0] act_frac;
  logic                 os_tick_r;
  logic                 mid_tick_r;
  logic                 baud_tick_r;

  logic                 idle;
  logic [WIDTH:0]       term;
  logic                 hit;
  logic                 baud_event;
  logic                 load;
  logic [FRAC_BITS:0]   acc_sum;

  always_comb begin
    idle       = !bus.enable || (act_div == '0);
    term       = {1'b0, act_div} + {{WIDTH{1'b0}}, ext};
    hit        = !bus.restart && !idle && (cnt == term);
    baud_event = hit && (sub == SUB_LAST);
    load       = !bus.enable || bus.restart || (act_div == '0) || baud_event;
    acc_sum    = {1'b0, acc} + {1'b0, act_frac};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sub         <= '0;
      acc         <= '0;
      ext         <= 1'b0;
      act_div     <= '0;
      act_frac    <= '0;
      os_tick_r   <= 1'b0;
      mid_tick_r  <= 1'b0;
      baud_tick_r <= 1'b0;
    end else begin
      // Divisor changes only land at bit boundaries or while stopped.
      if (load) begin
        act_div  <= bus.baud_division;
        act_frac <= bus.baud_frac;
      end
      if (bus.restart || idle) begin
        cnt         <= '0;
        sub         <= '0;
        acc         <= '0;
        ext         <= 1'b0;
        os_tick_r   <= 1'b0;
        mid_tick_r  <= 1'b0;
        baud_tick_r <= 1'b0;
      end else if (hit) begin
        cnt         <= '0;
        acc         <= acc_sum[FRAC_BITS-1:0];
        ext         <= acc_sum[FRAC_BITS];
        sub         <= sub + IDX_W'(1);
        os_tick_r   <= 1'b1;
        mid_tick_r  <= (sub == SUB_MID);
        baud_tick_r <= (sub == SUB_LAST);
      end else begin
        cnt         <= cnt + (WIDTH+1)'(1);
        os_tick_r   <= 1'b0;
        mid_tick_r  <= 1'b0;
        baud_tick_r <= 1'b0;
      end
    end
  end

  assign bus.os_tick   = os_tick_r;
  assign bus.mid_tick  = mid_tick_r;
  assign bus.baud_tick = baud_tick_r;
  assign bus.os_index  = sub;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - self-checking bench for uart_baud_gen_frac
module tb_uart_baud_gen_frac;
  localparam int WIDTH      = 32;
  localparam int FRAC_BITS  = 4;
  localparam int OVERSAMPLE = 16;
  localparam int FRAC_DEN   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  uart_baud_gen_frac_if #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .OVERSAMPLE(OVERSAMPLE)) bus();

  uart_baud_gen_frac #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart_pulse(input int d, input int f);
    bus.baud_division = WIDTH'(d);
    bus.baud_frac     = FRAC_BITS'(f);
    bus.enable        = 1'b1;
    bus.restart       = 1'b1;
    step();
    bus.restart       = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.restart = 1'b0; bus.baud_division = '0; bus.baud_frac = '0;
    rst = 1'b0;
    step(); step();
    tests++;
    if ({bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index} !== 7'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%b required=0", {bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index});
    end
    #3 rst = 1'b1;
    step(); step();
    tests++;
    if ({bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index} !== 7'd0) begin
      fails++;
      $display("FAIL idle_after_reset got=%b required=0", {bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index});
    end
  endtask

  task automatic test_integer_div();
    logic [6:0] got, exp;
    restart_pulse(3, 0);
    for (int i = 1; i <= 140; i++) begin
      step();
      got = {bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index};
      exp = {(i % 4 == 0), (i % 64 == 32), (i % 64 == 0), 4'((i / 4) % 16)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL integer_div cycle=%0d got=%b required=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_fractional();
    int os_cnt = 0;
    int baud_cnt = 0;
    int times[$];
    restart_pulse(3, 8);
    for (int i = 1; i <= 72; i++) begin
      step();
      if (bus.os_tick) begin os_cnt++; times.push_back(i); end
      if (bus.baud_tick) baud_cnt++;
    end
    tests++;
    if (os_cnt != 16) begin fails++; $display("FAIL frac_os_count got=%0d required=16", os_cnt); end
    tests++;
    if (baud_cnt != 1) begin fails++; $display("FAIL frac_baud_count got=%0d required=1", baud_cnt); end
    for (int k = 1; k <= 16 && k <= times.size(); k++) begin
      int exp_t;
      exp_t = 4 * k + ((k - 1) * 8) / FRAC_DEN;
      tests++;
      if (times[k-1] != exp_t) begin
        fails++;
        $display("FAIL frac_tick_time k=%0d got=%0d required=%0d", k, times[k-1], exp_t);
      end
    end
  endtask

  task automatic test_zero_div();
    int bad = 0;
    int first = -1;
    bus.enable = 1'b0; bus.baud_division = '0; bus.baud_frac = '0;
    step();
    bus.enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.os_tick || bus.mid_tick || bus.baud_tick || bus.os_index != 0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL zero_div_quiet got=%0d active cycles required=0", bad); end
    bus.baud_division = WIDTH'(1);
    for (int i = 1; i <= 3 && first < 0; i++) begin
      step();
      if (bus.os_tick) first = i;
    end
    tests++;
    if (first < 0) begin
      fails++;
      $display("FAIL zero_div_start got=no tick required=tick within 3 cycles");
    end else begin
      for (int i = 1; i <= 10; i++) begin
        step();
        tests++;
        if (bus.os_tick !== (i % 2 == 0)) begin
          fails++;
          $display("FAIL zero_div_spacing cycle=%0d got=%b required=%b", i, bus.os_tick, (i % 2 == 0));
        end
      end
    end
  endtask

  task automatic test_restart_run();
    restart_pulse(9, 0);
    for (int i = 0; i < 5; i++) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      tests++;
      if (bus.os_tick !== (i == 10)) begin
        fails++;
        $display("FAIL restart_mid cycle=%0d got=%b required=%b", i, bus.os_tick, (i == 10));
      end
    end
    for (int i = 0; i < 9; i++) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    tests++;
    if (bus.os_tick !== 1'b0) begin
      fails++;
      $display("FAIL restart_coincident got=%b required=0", bus.os_tick);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      tests++;
      if (bus.os_tick !== (i == 10)) begin
        fails++;
        $display("FAIL restart_after_coincident cycle=%0d got=%b required=%b", i, bus.os_tick, (i == 10));
      end
    end
  endtask

  task automatic test_shadow_load();
    int mid_at = -1;
    int baud_at = -1;
    int got[$];
    int exp[$];
    restart_pulse(3, 0);
    for (int i = 1; i <= 100 && mid_at < 0; i++) begin
      step();
      if (bus.mid_tick) mid_at = i;
    end
    tests++;
    if (mid_at != 32) begin fails++; $display("FAIL shadow_mid_time got=%0d required=32", mid_at); end
    bus.baud_division = WIDTH'(7);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (bus.os_tick) got.push_back(i);
      if (bus.baud_tick && baud_at < 0) baud_at = i;
    end
    for (int j = 1; j <= 8; j++) exp.push_back(4 * j);
    for (int j = 1; j <= 4; j++) exp.push_back(32 + 8 * j);
    tests++;
    if (baud_at != 32) begin fails++; $display("FAIL shadow_baud_time got=%0d required=32", baud_at); end
    tests++;
    if (got.size() != exp.size()) begin
      fails++;
      $display("FAIL shadow_tick_count got=%0d required=%0d", got.size(), exp.size());
    end
    for (int j = 0; j < exp.size() && j < got.size(); j++) begin
      tests++;
      if (got[j] != exp[j]) begin
        fails++;
        $display("FAIL shadow_tick_time idx=%0d got=%0d required=%0d", j, got[j], exp[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    restart_pulse(3, 0);
    for (int i = 0; i < 22; i++) step();
    #3 rst = 1'b0;
    #1;
    tests++;
    if ({bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index} !== 7'd0) begin
      fails++;
      $display("FAIL async_reset got=%b required=0", {bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index});
    end
    bus.enable = 1'b1; bus.baud_division = WIDTH'(3); bus.baud_frac = '0;
    step();
    #3 rst = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      tests++;
      if (bus.os_tick !== (n == 5)) begin
        fails++;
        $display("FAIL reset_release_start edge=%0d got=%b required=%b", n, bus.os_tick, (n == 5));
      end
    end
  endtask

  // Reference: tick k of a phase lands (act_div+1) cycles after the previous one, plus one
  // whenever the running total of fractions crosses a multiple of 2^FRAC_BITS.
  task automatic test_random();
    int next_t = 0, k = 0, fs = 0, md = 1, mf = 0, bd = 1, bf = 0, carry;
    bit rs;
    logic [6:0] got, exp;
    logic e_os, e_mid, e_baud;
    bus.enable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rs = (n == 0) || ($urandom_range(149, 0) == 0);
      if (n == 0 || $urandom_range(39, 0) == 0) begin
        bd = $urandom_range(5, 1);
        bf = $urandom_range(FRAC_DEN - 1, 0);
      end
      bus.restart = rs;
      bus.baud_division = WIDTH'(bd);
      bus.baud_frac = FRAC_BITS'(bf);
      step();
      e_os = 1'b0; e_mid = 1'b0; e_baud = 1'b0;
      if (rs) begin
        md = bd; mf = bf; k = 0; fs = 0;
        next_t = cyc + md + 1;
      end else if (cyc == next_t) begin
        carry = (fs + mf) / FRAC_DEN - fs / FRAC_DEN;
        fs += mf;
        k++;
        e_os = 1'b1;
        e_mid = (k % OVERSAMPLE == OVERSAMPLE / 2);
        e_baud = (k % OVERSAMPLE == 0);
        if (e_baud) begin md = bd; mf = bf; end
        next_t = cyc + md + 1 + carry;
      end
      got = {bus.os_tick, bus.mid_tick, bus.baud_tick, bus.os_index};
      exp = {e_os, e_mid, e_baud, 4'(k % OVERSAMPLE)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random cycle=%0d got=%b required=%b", n, got, exp);
      end
    end
    bus.restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_integer_div();
    test_fractional();
    test_zero_div();
    test_restart_run();
    test_shadow_load();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
